rc_servo_frame_scheduler: RTL and testbench

//   Frame-level sequencer for the XY servo path. Once per servo frame it

---
 rtl/rc_servo_frame_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rc_servo_frame_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rc_servo_frame_scheduler.sv
// XY servo frame sequencer: shared-DAC ramp measurement of X then Y, then X pulse followed by Y pulse.
// All outputs registered (1-cycle decisions); no backpressure, timing is fixed by the frame counter.
module rc_servo_frame_scheduler #(
  parameter int FRAME_LEN  = 200000,
  parameter int SETTLE     = 4,
  parameter int PULSE_MIN  = 10000,
  parameter int PULSE_STEP = 39
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ena_i,
  input  logic       comp_async_i,
  output logic [7:0] ramp_o,
  output logic       sel_y_o,
  output logic [7:0] pos_x_o,
  output logic [7:0] pos_y_o,
  output logic       pos_valid_o,
  output logic       pwm_x_o,
  output logic       pwm_y_o
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int SW = $clog2(SETTLE);

  typedef enum logic [2:0] {MEAS_X, MEAS_Y, PULSE_X, PULSE_Y, WAIT} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] fc_q, fc_n;
  logic [SW-1:0] settle_q, settle_n;
  logic [7:0]    ramp_q, ramp_n;
  logic          found_q, found_n;
  logic [7:0]    code_q, code_n;
  logic [7:0]    meas_x_q, meas_x_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          sel_y_q, sel_y_n;
  logic [7:0]    pos_x_q, pos_x_n;
  logic [7:0]    pos_y_q, pos_y_n;
  logic          pos_vld_q, pos_vld_n;
  logic          pwm_x_q, pwm_x_n;
  logic          pwm_y_q, pwm_y_n;
  logic          comp_m, comp_s;

  logic          step_end, hit, fc_wrap;
  logic [7:0]    code_fin;

  // Remaining pulse cycles minus one; W < FRAME_LEN so CW bits never overflow.
  function automatic logic [CW-1:0] pulse_last(input logic [7:0] code);
    return CW'(PULSE_MIN - 1) + CW'(code) * CW'(PULSE_STEP);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= MEAS_X;
      fc_q      <= '0;
      settle_q  <= '0;
      ramp_q    <= '0;
      found_q   <= 1'b0;
      code_q    <= '0;
      meas_x_q  <= '0;
      cnt_q     <= '0;
      sel_y_q   <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      pos_vld_q <= 1'b0;
      pwm_x_q   <= 1'b0;
      pwm_y_q   <= 1'b0;
      comp_m    <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      state_q   <= state_n;
      fc_q      <= fc_n;
      settle_q  <= settle_n;
      ramp_q    <= ramp_n;
      found_q   <= found_n;
      code_q    <= code_n;
      meas_x_q  <= meas_x_n;
      cnt_q     <= cnt_n;
      sel_y_q   <= sel_y_n;
      pos_x_q   <= pos_x_n;
      pos_y_q   <= pos_y_n;
      pos_vld_q <= pos_vld_n;
      pwm_x_q   <= pwm_x_n;
      pwm_y_q   <= pwm_y_n;
      comp_m    <= comp_async_i;
      comp_s    <= comp_m;
    end
  end

  always_comb begin
    step_end  = (settle_q == SW'(SETTLE - 1));
    hit       = step_end && comp_s && !found_q;
    code_fin  = found_q ? code_q : (hit ? ramp_q : 8'd255);
    fc_wrap   = (fc_q == CW'(FRAME_LEN - 1));

    state_n   = state_q;
    fc_n      = fc_wrap ? '0 : fc_q + CW'(1);
    settle_n  = '0;
    ramp_n    = '0;
    found_n   = found_q;
    code_n    = code_q;
    meas_x_n  = meas_x_q;
    cnt_n     = cnt_q;
    pos_x_n   = pos_x_q;
    pos_y_n   = pos_y_q;
    pos_vld_n = 1'b0;
    pwm_x_n   = 1'b0;
    pwm_y_n   = 1'b0;

    if (fc_wrap) begin
      state_n = ena_i ? MEAS_X : WAIT;
      found_n = 1'b0;
    end else if (!ena_i) begin
      state_n = WAIT;
    end else begin
      case (state_q)
        MEAS_X, MEAS_Y: begin
          settle_n = step_end ? '0 : settle_q + SW'(1);
          ramp_n   = step_end ? ramp_q + 8'd1 : ramp_q;
          if (hit) begin
            found_n = 1'b1;
            code_n  = ramp_q;
          end
          if (step_end && ramp_q == 8'd255) begin
            found_n = 1'b0;
            if (state_q == MEAS_X) begin
              meas_x_n = code_fin;
              state_n  = MEAS_Y;
            end else begin
              // Publish both codes and launch the X pulse in the same edge.
              pos_x_n   = meas_x_q;
              pos_y_n   = code_fin;
              pos_vld_n = 1'b1;
              pwm_x_n   = 1'b1;
              cnt_n     = pulse_last(meas_x_q);
              state_n   = PULSE_X;
            end
          end
        end
        PULSE_X: begin
          if (cnt_q == '0) begin
            pwm_y_n = 1'b1;
            cnt_n   = pulse_last(pos_y_q);
            state_n = PULSE_Y;
          end else begin
            pwm_x_n = 1'b1;
            cnt_n   = cnt_q - CW'(1);
          end
        end
        PULSE_Y: begin
          if (cnt_q == '0) begin
            state_n = WAIT;
          end else begin
            pwm_y_n = 1'b1;
            cnt_n   = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end

    sel_y_n = (state_n == MEAS_Y);
  end

  assign ramp_o      = ramp_q;
  assign sel_y_o     = sel_y_q;
  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign pos_valid_o = pos_vld_q;
  assign pwm_x_o     = pwm_x_q;
  assign pwm_y_o     = pwm_y_q;

endmodule

// File: tb/tb_rc_servo_frame_scheduler.sv
// Directed bench for rc_servo_frame_scheduler with a threshold comparator model.
module tb_rc_servo_frame_scheduler;

  localparam int FL = 4000;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ena_i = 1'b0;
  logic       comp_async;
  logic [7:0] ramp_o, pos_x_o, pos_y_o;
  logic       sel_y_o, pos_valid_o, pwm_x_o, pwm_y_o;

  int cmode = 0;  // 0 threshold model, 1 stuck 0, 2 stuck 1
  int n_chk = 0;
  int n_err = 0;
  int tb_fc = 0;
  int cyc = 0;

  int x_w, y_w, x_rise, y_rise, vld_cnt, vld_fc, px, py, px_pre, x_rise_abs;
  int overlap = 0;
  int xa, xb, xc;
  logic [7:0] rl [0:2099];
  logic       sl [0:2099];

  always #5 clk = ~clk;

  assign comp_async = (cmode == 1) ? 1'b0 :
                      (cmode == 2) ? 1'b1 :
                      (int'(ramp_o) >= (sel_y_o ? 37 : 100));

  rc_servo_frame_scheduler #(
    .FRAME_LEN (FL),
    .SETTLE    (4),
    .PULSE_MIN (100),
    .PULSE_STEP(2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .ena_i       (ena_i),
    .comp_async_i(comp_async),
    .ramp_o      (ramp_o),
    .sel_y_o     (sel_y_o),
    .pos_x_o     (pos_x_o),
    .pos_y_o     (pos_y_o),
    .pos_valid_o (pos_valid_o),
    .pwm_x_o     (pwm_x_o),
    .pwm_y_o     (pwm_y_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, ramp_o, sel_y_o, pos_x_o, pos_y_o, pos_valid_o, pwm_x_o, pwm_y_o};
  endfunction

  task automatic clear();
    x_w = 0; y_w = 0; x_rise = -1; y_rise = -1; x_rise_abs = -1;
    vld_cnt = 0; vld_fc = -1; px = -1; py = -1; px_pre = -1;
  endtask

  task automatic sample();
    if (pwm_x_o) begin
      if (x_w == 0) begin x_rise = tb_fc; x_rise_abs = cyc; end
      x_w++;
    end
    if (pwm_y_o) begin
      if (y_w == 0) y_rise = tb_fc;
      y_w++;
    end
    if (pwm_x_o && pwm_y_o) overlap++;
    if (pos_valid_o) begin
      vld_cnt++; vld_fc = tb_fc; px = int'(pos_x_o); py = int'(pos_y_o);
    end
    if (tb_fc < 2100) begin rl[tb_fc] = ramp_o; sl[tb_fc] = sel_y_o; end
    if (tb_fc == 2047) px_pre = int'(pos_x_o);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    tb_fc = (tb_fc == FL - 1) ? 0 : tb_fc + 1;
  endtask

  // Walks at least one cycle, bounded by one frame since fc wraps.
  task automatic run_to(input int t);
    do begin
      sample();
      tick();
    end while (tb_fc != t);
  endtask

  task automatic scan_frame();
    clear();
    run_to(0);
  endtask

  task automatic check_frame(input string tag, input int ex_px, input int ex_py);
    int wx, wy;
    wx = 100 + 2 * ex_px;
    wy = 100 + 2 * ex_py;
    chk({tag, "_vld_cnt"}, vld_cnt, 1);
    chk({tag, "_vld_fc"}, vld_fc, 2048);
    chk({tag, "_pos_x"}, px, ex_px);
    chk({tag, "_pos_y"}, py, ex_py);
    chk({tag, "_x_rise"}, x_rise, 2048);
    chk({tag, "_x_width"}, x_w, wx);
    chk({tag, "_y_rise"}, y_rise, 2048 + wx);
    chk({tag, "_y_width"}, y_w, wy);
  endtask

  initial begin
    reset_i = 1'b1;
    ena_i   = 1'b1;
    cmode   = 0;
    repeat (3) begin
      @(posedge clk); #1;
      cyc++;
      chk("reset_outs", all_outs(), 0);
    end
    reset_i = 1'b0;
    tb_fc   = 0;

    // Frame A: threshold comparator, 100 / 37
    scan_frame();
    xa = x_rise_abs;
    chk("ramp_fc0", rl[0], 0);
    chk("ramp_fc3", rl[3], 0);
    chk("ramp_fc4", rl[4], 1);
    chk("ramp_fc8", rl[8], 2);
    chk("ramp_fc1023", rl[1023], 255);
    chk("ramp_fc1024", rl[1024], 0);
    chk("ramp_fc1028", rl[1028], 1);
    chk("ramp_fc2048", rl[2048], 0);
    chk("sel_fc1023", sl[1023], 0);
    chk("sel_fc1024", sl[1024], 1);
    chk("sel_fc2047", sl[2047], 1);
    chk("sel_fc2048", sl[2048], 0);
    chk("pos_x_before_update", px_pre, 0);
    check_frame("thresh", 100, 37);
    chk("pos_x_hold", pos_x_o, 100);

    cmode = 1;
    scan_frame();
    xb = x_rise_abs;
    check_frame("stuck0", 255, 255);

    cmode = 2;
    scan_frame();
    xc = x_rise_abs;
    check_frame("stuck1", 0, 0);
    chk("x_period_ab", xb - xa, FL);
    chk("x_period_bc", xc - xb, FL);

    // ena_i dropped mid X pulse, raised again mid-frame
    cmode = 0;
    clear();
    run_to(2098);
    chk("ena_mid_pwm_x", pwm_x_o, 1);
    ena_i = 1'b0;
    tick();
    chk("ena_off_pwm_x", pwm_x_o, 0);
    chk("ena_off_pwm_y", pwm_y_o, 0);
    ena_i = 1'b1;
    clear();
    run_to(0);
    chk("ena_rest_x_width", x_w, 0);
    chk("ena_rest_y_width", y_w, 0);
    scan_frame();
    check_frame("resume", 100, 37);

    // Reset pulsed mid Y pulse
    clear();
    run_to(2398);
    chk("rst_mid_pwm_y", pwm_y_o, 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    cyc++;
    chk("rst_mid_outs", all_outs(), 0);
    reset_i = 1'b0;
    tb_fc   = 0;
    scan_frame();
    chk("rst_ramp_fc4", rl[4], 1);
    chk("rst_sel_fc1024", sl[1024], 1);
    chk("rst_pos_x_before", px_pre, 0);
    check_frame("after_reset", 100, 37);

    chk("pwm_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
